// File: rtl/rename_regfile_pkg.sv
// Shared constants for the rename register file slice: default geometry,
// the free-tag encoding for the default tag width, and checkpoint depth.
// The optional checkpoint feature is enabled with RENAME_CKPT_EN.
package rename_regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_RW    = 5;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_NRD   = 3;
  localparam int DEF_NCW   = 2;

  // All-ones tag means "no producer in flight, architectural value is ready".
  localparam logic [DEF_TAG_W-1:0] TAG_FREE = {DEF_TAG_W{1'b1}};

  // Tag-table snapshot depth used when RENAME_CKPT_EN is defined.
  localparam int NCKPT = 4;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rename_regfile_rdport.sv
// One combinational read port of the rename register file. Forwards data
// from same-cycle commit lanes (highest lane wins) and reports the tag as
// free when a same-cycle commit retires the current producer.
module rename_regfile_rdport
  import rename_regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int RW    = DEF_RW,
  parameter int TAG_W = DEF_TAG_W,
  parameter int NCW   = DEF_NCW
) (
  input  logic              live,
  input  logic [RW-1:0]     name,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [TAG_W-1:0]  reg_tag,
  input  logic [NCW-1:0]    cw_en,
  input  logic [NCW*RW-1:0] cw_name,
  input  logic [NCW*XLEN-1:0] cw_data,
  input  logic [NCW*TAG_W-1:0] cw_tag,
  output logic [XLEN-1:0]   data,
  output logic [TAG_W-1:0]  tag
);

  localparam logic [TAG_W-1:0] FREE = {TAG_W{1'b1}};

  logic [NCW-1:0]  lane_hit_s;
  logic [XLEN-1:0] byp_data_s;
  logic            clr_s;

  // Which commit lanes target the register this port is reading.
  always_comb begin
    lane_hit_s = '0;
    for (int l = 0; l < NCW; l++) begin
      lane_hit_s[l] = cw_en[l] && (cw_name[l*RW +: RW] == name);
    end
  end

  // Bypass scan: later lanes are younger and overwrite earlier ones.
  always_comb begin
    byp_data_s = reg_data;
    clr_s      = 1'b0;
    for (int l = 0; l < NCW; l++) begin
      byp_data_s = lane_hit_s[l] ? cw_data[l*XLEN +: XLEN] : byp_data_s;
      clr_s      = clr_s | (lane_hit_s[l] && (cw_tag[l*TAG_W +: TAG_W] == reg_tag));
    end
  end

  // Register zero, out-of-range names and reset all read as zero / free.
  always_comb begin
    if (!live || (name == '0)) begin
      data = '0;
      tag  = FREE;
    end else begin
      data = byp_data_s;
      tag  = clr_s ? FREE : reg_tag;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags. Accepts NCW
// in-order commit lanes, one dispatch tag write and a global flush, and
// serves NRD combinational read ports with commit bypass.
// Optional tag-table checkpoints are compiled in with RENAME_CKPT_EN.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = DEF_NREG,
  parameter int RW    = DEF_RW,
  parameter int TAG_W = DEF_TAG_W,
  parameter int NRD   = DEF_NRD,
  parameter int NCW   = DEF_NCW
`ifdef RENAME_CKPT_EN
  ,
  parameter int NCK   = NCKPT,
  parameter int CK_W  = idx_width(NCK)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [NCW-1:0]       cw_en,
  input  logic [NCW*RW-1:0]    cw_name,
  input  logic [NCW*XLEN-1:0]  cw_data,
  input  logic [NCW*TAG_W-1:0] cw_tag,
  input  logic                 dw_en,
  input  logic [RW-1:0]        dw_name,
  input  logic [TAG_W-1:0]     dw_tag,
`ifdef RENAME_CKPT_EN
  input  logic                 ck_save,
  input  logic [CK_W-1:0]      ck_save_id,
  input  logic                 ck_restore,
  input  logic [CK_W-1:0]      ck_restore_id,
`endif
  input  logic [NRD*RW-1:0]    rd_name,
  output logic [NRD*TAG_W-1:0] rd_tag,
  output logic [NRD*XLEN-1:0]  rd_data
);

  localparam logic [TAG_W-1:0] FREE   = {TAG_W{1'b1}};
  localparam logic [RW:0]      NREG_X = (RW+1)'(NREG);

  logic [XLEN-1:0]  data_r     [NREG];
  logic [TAG_W-1:0] tag_r      [NREG];
  logic [XLEN-1:0]  data_nxt_s [NREG];
  logic [TAG_W-1:0] tag_nxt_s  [NREG];
  logic [NREG-1:0]  wr_s       [NCW];
  logic [NREG-1:0]  clr_s;

`ifdef RENAME_CKPT_EN
  logic [TAG_W-1:0] snap_r     [NCK][NREG];
  logic [TAG_W-1:0] snap_clr_s [NCK][NREG];
  logic [TAG_W-1:0] snap_nxt_s [NCK][NREG];
`endif

  // Decode which lane writes which register; register 0 is never written.
  always_comb begin
    for (int l = 0; l < NCW; l++) begin
      wr_s[l] = '0;
      for (int r = 1; r < NREG; r++) begin
        wr_s[l][r] = cw_en[l] && (cw_name[l*RW +: RW] == RW'(r));
      end
    end
  end

  // A register's tag retires when any lane commits its current producer.
  always_comb begin
    clr_s = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int l = 0; l < NCW; l++) begin
        clr_s[r] = clr_s[r] | (wr_s[l][r] && (cw_tag[l*TAG_W +: TAG_W] == tag_r[r]));
      end
    end
  end

`ifdef RENAME_CKPT_EN
  // Snapshot entries retire on the same commits, matched against their own tag.
  always_comb begin
    for (int k = 0; k < NCK; k++) begin
      for (int r = 0; r < NREG; r++) begin
        snap_clr_s[k][r] = snap_r[k][r];
        for (int l = 0; l < NCW; l++) begin
          snap_clr_s[k][r] = (wr_s[l][r] && (cw_tag[l*TAG_W +: TAG_W] == snap_r[k][r])) ?
                             FREE : snap_clr_s[k][r];
        end
      end
    end
  end
`endif

  // Next architectural state, in priority order: commit clear, dispatch,
  // checkpoint restore, flush. Data writes are independent of tag overrides.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      data_nxt_s[r] = data_r[r];
      for (int l = 0; l < NCW; l++) begin
        data_nxt_s[r] = wr_s[l][r] ? cw_data[l*XLEN +: XLEN] : data_nxt_s[r];
      end
      tag_nxt_s[r] = clr_s[r] ? FREE : tag_r[r];
      if (dw_en && (r != 0) && (dw_name == RW'(r))) begin
        tag_nxt_s[r] = dw_tag;
      end else begin
        tag_nxt_s[r] = tag_nxt_s[r];
      end
`ifdef RENAME_CKPT_EN
      tag_nxt_s[r] = ck_restore ? snap_clr_s[ck_restore_id][r] : tag_nxt_s[r];
`endif
      if (flush) begin
        tag_nxt_s[r] = FREE;
      end else begin
        tag_nxt_s[r] = tag_nxt_s[r];
      end
    end
  end

`ifdef RENAME_CKPT_EN
  // Save captures the post-update table unless a restore wins the cycle.
  always_comb begin
    for (int k = 0; k < NCK; k++) begin
      for (int r = 0; r < NREG; r++) begin
        if (ck_save && !ck_restore && (ck_save_id == CK_W'(k))) begin
          snap_nxt_s[k][r] = tag_nxt_s[r];
        end else begin
          snap_nxt_s[k][r] = snap_clr_s[k][r];
        end
      end
    end
  end
`endif

  // State registers: async clear, otherwise advance only while rdy is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_r[r] <= '0;
        tag_r[r]  <= FREE;
      end
`ifdef RENAME_CKPT_EN
      for (int k = 0; k < NCK; k++) begin
        for (int r = 0; r < NREG; r++) begin
          snap_r[k][r] <= FREE;
        end
      end
`endif
    end else if (rdy) begin
      for (int r = 0; r < NREG; r++) begin
        data_r[r] <= data_nxt_s[r];
        tag_r[r]  <= tag_nxt_s[r];
      end
`ifdef RENAME_CKPT_EN
      for (int k = 0; k < NCK; k++) begin
        for (int r = 0; r < NREG; r++) begin
          snap_r[k][r] <= snap_nxt_s[k][r];
        end
      end
`endif
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [RW-1:0]    name_s;
    logic             in_range_s;
    logic [XLEN-1:0]  reg_data_s;
    logic [TAG_W-1:0] reg_tag_s;

    assign name_s     = rd_name[p*RW +: RW];
    assign in_range_s = ({1'b0, name_s} < NREG_X);
    assign reg_data_s = in_range_s ? data_r[name_s] : '0;
    assign reg_tag_s  = in_range_s ? tag_r[name_s]  : FREE;

    rename_regfile_rdport #(
      .XLEN  (XLEN),
      .RW    (RW),
      .TAG_W (TAG_W),
      .NCW   (NCW)
    ) u_rdport (
      .live     (rst & in_range_s),
      .name     (name_s),
      .reg_data (reg_data_s),
      .reg_tag  (reg_tag_s),
      .cw_en    (cw_en),
      .cw_name  (cw_name),
      .cw_data  (cw_data),
      .cw_tag   (cw_tag),
      .data     (rd_data[p*XLEN +: XLEN]),
      .tag      (rd_tag[p*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios pinned with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural register/tag model.
module tb_rename_regfile;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RW    = 5;
  localparam int TAG_W = 4;
  localparam int NRD   = 3;
  localparam int NCW   = 2;
  localparam logic [TAG_W-1:0] FREE = 4'hF;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 rdy, flush, dw_en;
  logic [NCW-1:0]       cw_en;
  logic [NCW*RW-1:0]    cw_name;
  logic [NCW*XLEN-1:0]  cw_data;
  logic [NCW*TAG_W-1:0] cw_tag;
  logic [RW-1:0]        dw_name;
  logic [TAG_W-1:0]     dw_tag;
  logic [NRD*RW-1:0]    rd_name;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic [NRD*XLEN-1:0]  rd_data;
`ifdef RENAME_CKPT_EN
  logic       ck_save, ck_restore;
  logic [1:0] ck_save_id, ck_restore_id;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0]  m_data [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  always #5 clk = ~clk;

  rename_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .flush   (flush),
    .cw_en   (cw_en),
    .cw_name (cw_name),
    .cw_data (cw_data),
    .cw_tag  (cw_tag),
    .dw_en   (dw_en),
    .dw_name (dw_name),
    .dw_tag  (dw_tag),
`ifdef RENAME_CKPT_EN
    .ck_save       (ck_save),
    .ck_save_id    (ck_save_id),
    .ck_restore    (ck_restore),
    .ck_restore_id (ck_restore_id),
`endif
    .rd_name (rd_name),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; dw_en = 1'b0; dw_name = '0; dw_tag = '0;
    cw_en = '0; cw_name = '0; cw_data = '0; cw_tag = '0;
`ifdef RENAME_CKPT_EN
    ck_save = 1'b0; ck_save_id = '0; ck_restore = 1'b0; ck_restore_id = '0;
`endif
  endtask

  task automatic set_lane(input int l, input int name, input int tag, input logic [XLEN-1:0] d);
    cw_en[l] = 1'b1;
    cw_name[l*RW +: RW]      = RW'(name);
    cw_tag[l*TAG_W +: TAG_W] = TAG_W'(tag);
    cw_data[l*XLEN +: XLEN]  = d;
  endtask

  task automatic dispatch(input int name, input int tag);
    dw_en = 1'b1; dw_name = RW'(name); dw_tag = TAG_W'(tag);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_data[r] = '0;
      m_tag[r]  = FREE;
    end
  endtask

  // Expected read result straight from the read rules.
  task automatic check_reads(input string what);
    for (int p = 0; p < NRD; p++) begin
      logic [RW-1:0]    n;
      logic [XLEN-1:0]  ed;
      logic [TAG_W-1:0] et;
      logic             retired;
      n = rd_name[p*RW +: RW];
      ed = '0; et = FREE; retired = 1'b0;
      if (rst && n != 0) begin
        ed = m_data[n];
        for (int l = 0; l < NCW; l++) begin
          if (cw_en[l] && cw_name[l*RW +: RW] == n) begin
            ed = cw_data[l*XLEN +: XLEN];
            if (cw_tag[l*TAG_W +: TAG_W] == m_tag[n]) retired = 1'b1;
          end
        end
        et = retired ? FREE : m_tag[n];
      end
      chk($sformatf("%s rd_data[%0d] r%0d", what, p, n), 64'(rd_data[p*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("%s rd_tag[%0d] r%0d", what, p, n), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
    end
  endtask

  // Apply one clock of the update rules to the model, lowest priority first.
  task automatic model_update();
    logic [TAG_W-1:0] old_tag [NREG];
    if (!rst || !rdy) return;
    for (int r = 0; r < NREG; r++) old_tag[r] = m_tag[r];
    for (int l = 0; l < NCW; l++) begin
      int n;
      n = int'(cw_name[l*RW +: RW]);
      if (cw_en[l] && n != 0) begin
        m_data[n] = cw_data[l*XLEN +: XLEN];
        if (cw_tag[l*TAG_W +: TAG_W] == old_tag[n]) m_tag[n] = FREE;
      end
    end
    if (dw_en && dw_name != 0) m_tag[dw_name] = dw_tag;
    if (flush) for (int r = 0; r < NREG; r++) m_tag[r] = FREE;
  endtask

  task automatic cycle(input string what);
    @(negedge clk);
    check_reads(what);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation on read port 0 with the current inputs applied.
  task automatic lit(input string what, input int r, input logic [XLEN-1:0] ed, input logic [TAG_W-1:0] et);
    rd_name[0 +: RW] = RW'(r);
    #1;
    chk({what, " data"}, 64'(rd_data[0 +: XLEN]), 64'(ed));
    chk({what, " tag"}, 64'(rd_tag[0 +: TAG_W]), 64'(et));
  endtask

  initial begin
    idle();
    rd_name = '0;
    model_reset();
    #12;
    lit("reset held r5", 5, 32'h0, FREE);
    @(negedge clk);
    rst = 1'b1;
    resync();
    lit("after reset r0", 0, 32'h0, FREE);
    lit("after reset r7", 7, 32'h0, FREE);

    // Dispatch then commit the same producer: bypass and retire.
    idle(); dispatch(5, 3); rd_name = {RW'(0), RW'(0), RW'(5)};
    cycle("t2 disp");
    idle(); set_lane(0, 5, 3, 32'hAB);
    lit("t2 same-cycle r5", 5, 32'hAB, FREE);
    cycle("t2 commit");
    idle(); lit("t2 next r5", 5, 32'hAB, FREE);

    // Commit of an older producer writes data but keeps the newer tag.
    idle(); dispatch(5, 3); cycle("t3 disp3");
    idle(); dispatch(5, 7); cycle("t3 disp7");
    idle(); set_lane(0, 5, 3, 32'h11); cycle("t3 stale");
    idle(); lit("t3 r5", 5, 32'h11, 4'h7);

    // Two lanes to one register: highest lane's data, tag retires.
    idle(); dispatch(2, 2); cycle("t4 disp");
    idle(); set_lane(0, 2, 1, 32'h1); set_lane(1, 2, 2, 32'h2);
    lit("t4 same-cycle r2", 2, 32'h2, FREE);
    cycle("t4 dual");
    idle(); lit("t4 r2", 2, 32'h2, FREE);
    idle(); dispatch(2, 2); cycle("t4 disp again");
    idle(); set_lane(0, 2, 1, 32'h1); set_lane(1, 2, 2, 32'h2); dispatch(2, 9);
    lit("t4 no dispatch forward", 2, 32'h2, FREE);
    cycle("t4 dual+disp");
    idle(); lit("t4 disp wins", 2, 32'h2, 4'h9);

    // Everything busy, then flush with a concurrent dispatch and commit.
    for (int r = 1; r < NREG; r++) begin
      idle(); dispatch(r, r % 15); cycle("t5 fill");
    end
    idle(); lit("t5 r9 busy", 9, 32'h0, 4'h9);
    idle(); flush = 1'b1; dispatch(4, 6); set_lane(0, 4, 0, 32'h55);
    cycle("t5 flush");
    idle();
    lit("t5 r4", 4, 32'h55, FREE);
    lit("t5 r1", 1, 32'h0, FREE);
    lit("t5 r31", 31, 32'h0, FREE);
    for (int r = 0; r < NREG; r++) begin
      rd_name = {RW'(r), RW'(r), RW'(r)};
      #1;
      check_reads("t5 sweep");
    end
    resync();

    // Randomized traffic, biased to a few registers so lanes collide.
    for (int i = 0; i < 600; i++) begin
      idle();
      rdy   = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int l = 0; l < NCW; l++) begin
        int n;
        n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
          set_lane(l, n, ($urandom_range(0, 1) == 1) ? int'(m_tag[n]) : int'($urandom_range(0, 15)), $urandom);
        end
      end
      if ($urandom_range(0, 1) == 1) dispatch($urandom_range(0, 7), $urandom_range(0, 14));
      for (int p = 0; p < NRD; p++) begin
        rd_name[p*RW +: RW] = ($urandom_range(0, 1) == 1) ? cw_name[($urandom_range(0, 1))*RW +: RW]
                                                           : RW'($urandom_range(0, 9));
      end
      cycle("rand");
    end

    // Reset asserted mid-cycle with commits active: outputs clear immediately.
    idle(); set_lane(0, 3, 0, 32'hDEAD); set_lane(1, 4, 1, 32'hBEEF);
    rd_name = {RW'(4), RW'(3), RW'(2)};
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid reset port0 data", 64'(rd_data[0 +: XLEN]), 64'h0);
    chk("mid reset port1 data", 64'(rd_data[XLEN +: XLEN]), 64'h0);
    chk("mid reset port2 tag", 64'(rd_tag[2*TAG_W +: TAG_W]), 64'hF);
    check_reads("mid reset");
    @(negedge clk);
    rst = 1'b1;
    idle();
    resync();
    for (int r = 0; r < NREG; r++) begin
      rd_name = {RW'(r), RW'(r), RW'(r)};
      #1;
      check_reads("post reset sweep");
    end
    resync();
    lit("post reset r2", 2, 32'h0, FREE);

`ifdef RENAME_CKPT_EN
    // Save with r3 busy, redispatch, retire the saved producer, restore.
    idle(); dispatch(3, 2); ck_save = 1'b1; ck_save_id = 2'd0; resync();
    idle(); dispatch(3, 5); resync();
    idle(); lit("ckpt r3 busy", 3, 32'h0, 4'h5);
    set_lane(0, 3, 2, 32'h33); resync();
    idle(); lit("ckpt r3 stale commit", 3, 32'h33, 4'h5);
    ck_restore = 1'b1; ck_restore_id = 2'd0; resync();
    idle(); lit("ckpt restored r3", 3, 32'h33, FREE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
